// File: rtl/rst_release_seq.sv
// rst_release_seq
//
// Reset controller for the rest of the design.
// - The raw board reset asserts asynchronously and is released synchronously to clk.
// - After a stretch period, NUM_OUT downstream reset domains are released one at a
//   time, in order, with bit 0 released first.
// - A synchronous soft-reset request re-runs the release sequence. It does not
//   touch the synchronized reset.
//
// Ports
//   clk            in   1        clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   sw_rst_req_i   in   1        soft-reset request, level-sampled on clk
//   rst_sync_n_o   out  1        rst_n, async-assert / sync-deassert
//   rst_seq_n_o    out  NUM_OUT  sequenced active-low resets, bit 0 first
//   busy_o         out  1        high while any rst_seq_n_o bit is low
//   rst_evt_cnt_o  out  8        accepted soft-reset count, saturating
//                                (only when RST_SEQ_EVT_CNT_EN is defined)
//
// Optional feature macro: RST_SEQ_EVT_CNT_EN

module rst_release_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int NUM_OUT        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req_i,
    output logic               rst_sync_n_o,
    output logic [NUM_OUT-1:0] rst_seq_n_o,
    output logic               busy_o
`ifdef RST_SEQ_EVT_CNT_EN
    ,
    output logic [7:0]         rst_evt_cnt_o
`endif
);

    localparam int MAX_CNT = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_STRETCH,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      idx_q;
    logic [NUM_OUT-1:0] seq_q;
    logic               busy_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               soft_acc;

    // Reset synchronizer: ones shift in from the bottom.
    // The top flop is the synchronized reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n_o = sync_q[SYNC_STAGES-1];

    // The FSM ignores soft requests until the synchronized reset has been released.
    assign soft_acc = sw_rst_req_i && (state_q != ST_SYNC);

    // Release sequencer.
    // SYNC leaves on the same edge that loads a 1 into the top synchronizer flop.
    // From that edge and from a soft-reset edge, cnt starts at 1 and bit 0 is
    // released when cnt equals STRETCH_CYCLES. Both paths therefore place bit 0
    // STRETCH_CYCLES edges after the point where the stretch starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            busy_q  <= 1'b1;
        end else if (soft_acc) begin
            state_q <= ST_STRETCH;
            cnt_q   <= CW'(1);
            idx_q   <= '0;
            seq_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (sync_q[SYNC_STAGES-2]) begin
                        state_q <= ST_STRETCH;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q == CW'(STRETCH_CYCLES)) begin
                        seq_q[0] <= 1'b1;
                        cnt_q    <= '0;
                        if (NUM_OUT == 1) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RELEASE;
                            idx_q   <= IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        seq_q[idx_q] <= 1'b1;
                        cnt_q        <= '0;
                        if (idx_q == IW'(NUM_OUT - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign rst_seq_n_o = seq_q;
    assign busy_o      = busy_q;

`ifdef RST_SEQ_EVT_CNT_EN
    logic       acc_q;
    logic [7:0] evt_q;

    // A request held high over several edges counts only once.
    // The counter increments only on a rising edge of the accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            evt_q <= '0;
        end else begin
            acc_q <= soft_acc;
            if (soft_acc && !acc_q && (evt_q != 8'hFF)) begin
                evt_q <= evt_q + 8'd1;
            end
        end
    end

    assign rst_evt_cnt_o = evt_q;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq
//
// Directed bench for rst_release_seq with the default parameters.
// Edge numbering: edge 1 is the first rising clk edge after rst_n is released.
// Outputs are sampled 1 time unit after each rising edge.

module tb_rst_release_seq;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req_i;
    logic       rst_sync_n_o;
    logic [2:0] rst_seq_n_o;
    logic       busy_o;
`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0] rst_evt_cnt_o;
`endif

    int total;
    int bad;
    int e;

    rst_release_seq #(
        .SYNC_STAGES   (2),
        .STRETCH_CYCLES(16),
        .GAP_CYCLES    (4),
        .NUM_OUT       (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req_i (sw_rst_req_i),
        .rst_sync_n_o (rst_sync_n_o),
        .rst_seq_n_o  (rst_seq_n_o),
        .busy_o       (busy_o)
`ifdef RST_SEQ_EVT_CNT_EN
        ,
        .rst_evt_cnt_o(rst_evt_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected release pattern: bit k is high from edge base + 4*k onward.
    function automatic logic [2:0] exp_seq(input int edge_no, input int base);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 0; k < 3; k++) begin
            r[k] = (edge_no >= base + 4 * k);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        e = e + 1;
    endtask

    task automatic hold_reset(input logic sw_at_release);
        rst_n = 1'b0;
        sw_rst_req_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sw_rst_req_i = sw_at_release;
        e = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        sw_rst_req_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (rst_sync_n_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_sync got=%b want=0", rst_sync_n_o);
        end
        total++;
        if (rst_seq_n_o !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_seq got=%b want=000", rst_seq_n_o);
        end
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_busy got=%b want=1", busy_o);
        end
`ifdef RST_SEQ_EVT_CNT_EN
        total++;
        if (rst_evt_cnt_o !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_evt got=%0d want=0", rst_evt_cnt_o);
        end
`endif
    endtask

    task automatic test_power_up();
        hold_reset(1'b0);
        for (int i = 1; i <= 30; i++) begin
            step();
            total++;
            if (rst_sync_n_o !== (e >= 2)) begin
                bad++;
                $display("[TB] FAIL pwr_sync edge=%0d got=%b want=%b", e, rst_sync_n_o, (e >= 2));
            end
            total++;
            if (rst_seq_n_o !== exp_seq(e, 18)) begin
                bad++;
                $display("[TB] FAIL pwr_seq edge=%0d got=%b want=%b", e, rst_seq_n_o, exp_seq(e, 18));
            end
            total++;
            if (busy_o !== (e < 26)) begin
                bad++;
                $display("[TB] FAIL pwr_busy edge=%0d got=%b want=%b", e, busy_o, (e < 26));
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rst_sync_n_o, rst_seq_n_o, busy_o} !== 5'b0_000_1) begin
            bad++;
            $display("[TB] FAIL async_assert got=%b want=00001", {rst_sync_n_o, rst_seq_n_o, busy_o});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            total++;
            if (rst_sync_n_o !== (e >= 2)) begin
                bad++;
                $display("[TB] FAIL rerun_sync edge=%0d got=%b want=%b", e, rst_sync_n_o, (e >= 2));
            end
            total++;
            if (rst_seq_n_o !== exp_seq(e, 18)) begin
                bad++;
                $display("[TB] FAIL rerun_seq edge=%0d got=%b want=%b", e, rst_seq_n_o, exp_seq(e, 18));
            end
            total++;
            if (busy_o !== (e < 26)) begin
                bad++;
                $display("[TB] FAIL rerun_busy edge=%0d got=%b want=%b", e, busy_o, (e < 26));
            end
        end
    endtask

    task automatic test_soft_in_done();
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        total++;
        if ({rst_sync_n_o, rst_seq_n_o, busy_o} !== 5'b1_000_1) begin
            bad++;
            $display("[TB] FAIL soft_done_hit got=%b want=10001", {rst_sync_n_o, rst_seq_n_o, busy_o});
        end
        for (int j = 1; j <= 28; j++) begin
            step();
            total++;
            if (rst_seq_n_o !== exp_seq(j, 16)) begin
                bad++;
                $display("[TB] FAIL soft_done_seq R+%0d got=%b want=%b", j, rst_seq_n_o, exp_seq(j, 16));
            end
            total++;
            if (rst_sync_n_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL soft_done_sync R+%0d got=%b want=1", j, rst_sync_n_o);
            end
            total++;
            if (busy_o !== (j < 24)) begin
                bad++;
                $display("[TB] FAIL soft_done_busy R+%0d got=%b want=%b", j, busy_o, (j < 24));
            end
        end
    endtask

    task automatic test_soft_mid_release();
        hold_reset(1'b0);
        repeat (19) step();
        total++;
        if (rst_seq_n_o !== 3'b001) begin
            bad++;
            $display("[TB] FAIL mid_pre edge=%0d got=%b want=001", e, rst_seq_n_o);
        end
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        total++;
        if ({rst_seq_n_o, busy_o} !== 4'b000_1) begin
            bad++;
            $display("[TB] FAIL mid_hit edge=%0d got=%b want=0001", e, {rst_seq_n_o, busy_o});
        end
        for (int i = 21; i <= 48; i++) begin
            step();
            total++;
            if (rst_seq_n_o !== exp_seq(e, 36)) begin
                bad++;
                $display("[TB] FAIL mid_seq edge=%0d got=%b want=%b", e, rst_seq_n_o, exp_seq(e, 36));
            end
        end
    endtask

    task automatic test_soft_held();
        hold_reset(1'b1);
        for (int i = 1; i <= 34; i++) begin
            step();
            if (e == 10) sw_rst_req_i = 1'b0;
            total++;
            if (rst_sync_n_o !== (e >= 2)) begin
                bad++;
                $display("[TB] FAIL held_sync edge=%0d got=%b want=%b", e, rst_sync_n_o, (e >= 2));
            end
            total++;
            if (rst_seq_n_o !== exp_seq(e, 26)) begin
                bad++;
                $display("[TB] FAIL held_seq edge=%0d got=%b want=%b", e, rst_seq_n_o, exp_seq(e, 26));
            end
        end
`ifdef RST_SEQ_EVT_CNT_EN
        total++;
        if (rst_evt_cnt_o !== 8'd1) begin
            bad++;
            $display("[TB] FAIL held_evt got=%0d want=1", rst_evt_cnt_o);
        end
`endif
    endtask

`ifdef RST_SEQ_EVT_CNT_EN
    task automatic test_evt_cnt();
        hold_reset(1'b1);
        step();
        sw_rst_req_i = 1'b0;
        repeat (3) step();
        total++;
        if (rst_evt_cnt_o !== 8'd0) begin
            bad++;
            $display("[TB] FAIL evt_sync_ignored got=%0d want=0", rst_evt_cnt_o);
        end
        sw_rst_req_i = 1'b1;
        repeat (4) step();
        sw_rst_req_i = 1'b0;
        step();
        total++;
        if (rst_evt_cnt_o !== 8'd1) begin
            bad++;
            $display("[TB] FAIL evt_held_once got=%0d want=1", rst_evt_cnt_o);
        end
        for (int p = 2; p <= 300; p++) begin
            sw_rst_req_i = 1'b1;
            step();
            sw_rst_req_i = 1'b0;
            step();
            if (p == 2 || p == 254 || p == 255 || p == 300) begin
                total++;
                if (rst_evt_cnt_o !== ((p > 255) ? 8'd255 : 8'(p))) begin
                    bad++;
                    $display("[TB] FAIL evt_pulse p=%0d got=%0d want=%0d", p, rst_evt_cnt_o,
                             (p > 255) ? 255 : p);
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rst_evt_cnt_o !== 8'd0) begin
            bad++;
            $display("[TB] FAIL evt_clear got=%0d want=0", rst_evt_cnt_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        e = 0;
        test_reset();
        test_power_up();
        test_async_reset();
        test_soft_in_done();
        test_soft_mid_release();
        test_soft_held();
`ifdef RST_SEQ_EVT_CNT_EN
        test_evt_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
